// File: rtl/mm_job_scheduler_pkg.sv
// Shared types and constants for the matrix-multiply job scheduler.
// FSM encodings, completion error codes and descriptor sizing.
package mm_job_scheduler_pkg;

  localparam int ADDR_WIDTH_DEF = 32;
  localparam int DIM_W          = 4;
  localparam int TAG_W          = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_RUN    = 2'd2,
    ST_REPORT = 2'd3
  } state_e;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_ZERO_DIM = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

  // Packed descriptor: {addra, addrb, addrp, k, m, n, tag}
  function automatic int desc_width(input int aw);
    return 3 * aw + 3 * DIM_W + TAG_W;
  endfunction

endpackage

// File: rtl/mm_job_scheduler_job_fifo.sv
// Single-clock FIFO holding packed job descriptors; head visible combinationally, count registered.
// Push is refused while full even if a pop happens in the same cycle; pointers wrap modulo DEPTH.
module job_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           din_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           dout_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_en, pop_en;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  assign push_en = push_i && !full_o;
  assign pop_en  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_en)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_en, pop_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset: occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (push_en) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/mm_job_scheduler.sv
// Queues host job descriptors, launches them one at a time on the mm controller and reports completions.
// Start 2 cycles after push when idle, done 1 cycle after ctrl pulse; done record held until done_ready_i.
module mm_job_scheduler
  import mm_job_scheduler_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DEPTH      = 4,
  parameter int TO_W       = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       job_valid_i,
  output logic                       job_ready_o,
  input  logic [ADDR_WIDTH-1:0]      job_addra_i,
  input  logic [ADDR_WIDTH-1:0]      job_addrb_i,
  input  logic [ADDR_WIDTH-1:0]      job_addrp_i,
  input  logic [DIM_W-1:0]           job_k_i,
  input  logic [DIM_W-1:0]           job_m_i,
  input  logic [DIM_W-1:0]           job_n_i,
  input  logic [TAG_W-1:0]           job_tag_i,
  input  logic [TO_W-1:0]            timeout_cycles_i,
  output logic                       start_o,
  output logic [ADDR_WIDTH-1:0]      base_addra_o,
  output logic [ADDR_WIDTH-1:0]      base_addrb_o,
  output logic [ADDR_WIDTH-1:0]      base_addrp_o,
  output logic [DIM_W-1:0]           k_o,
  output logic [DIM_W-1:0]           m_o,
  output logic [DIM_W-1:0]           n_o,
  input  logic                       ctrl_valid_i,
  output logic                       done_valid_o,
  input  logic                       done_ready_i,
  output logic [TAG_W-1:0]           done_tag_o,
  output logic [1:0]                 done_err_o,
  output logic                       busy_o,
  output logic [$clog2(DEPTH+1)-1:0] pending_o
);

  localparam int DW = desc_width(ADDR_WIDTH);

  state_e                state_q, state_d;
  logic [TO_W-1:0]       cnt_q, cnt_d;
  logic [1:0]            err_q, err_d;
  logic [ADDR_WIDTH-1:0] addra_q, addrb_q, addrp_q;
  logic [DIM_W-1:0]      k_q, m_q, n_q;
  logic [TAG_W-1:0]      tag_q;

  logic [DW-1:0]         fifo_din, fifo_dout;
  logic                  fifo_full, fifo_empty, fifo_pop;

  logic [ADDR_WIDTH-1:0] h_addra, h_addrb, h_addrp;
  logic [DIM_W-1:0]      h_k, h_m, h_n;
  logic [TAG_W-1:0]      h_tag;
  logic                  h_zero_dim;

  assign fifo_din = {job_addra_i, job_addrb_i, job_addrp_i, job_k_i, job_m_i, job_n_i, job_tag_i};
  assign {h_addra, h_addrb, h_addrp, h_k, h_m, h_n, h_tag} = fifo_dout;
  assign h_zero_dim = (h_k == '0) || (h_m == '0) || (h_n == '0);

  job_fifo #(
    .WIDTH (DW),
    .DEPTH (DEPTH)
  ) u_job_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (job_valid_i),
    .din_i   (fifo_din),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (pending_o)
  );

  assign job_ready_o = !fifo_full;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    fifo_pop = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (h_zero_dim) begin
            state_d = ST_REPORT;
            err_d   = ERR_ZERO_DIM;
          end else begin
            state_d = ST_LAUNCH;
            err_d   = ERR_OK;
          end
        end
      end
      ST_LAUNCH: begin
        cnt_d   = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        cnt_d = cnt_q + TO_W'(1);
        // A completion arriving on the timeout cycle still counts as success.
        if (ctrl_valid_i) begin
          state_d = ST_REPORT;
          err_d   = ERR_OK;
        end else if ((timeout_cycles_i != '0) && (cnt_q == timeout_cycles_i - TO_W'(1))) begin
          state_d = ST_REPORT;
          err_d   = ERR_TIMEOUT;
        end
      end
      ST_REPORT: begin
        if (done_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      err_q   <= ERR_OK;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Active job registers change only when a descriptor leaves the FIFO.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addra_q <= '0;
      addrb_q <= '0;
      addrp_q <= '0;
      k_q     <= '0;
      m_q     <= '0;
      n_q     <= '0;
      tag_q   <= '0;
    end else if (fifo_pop) begin
      addra_q <= h_addra;
      addrb_q <= h_addrb;
      addrp_q <= h_addrp;
      k_q     <= h_k;
      m_q     <= h_m;
      n_q     <= h_n;
      tag_q   <= h_tag;
    end
  end

  assign start_o      = (state_q == ST_LAUNCH);
  assign done_valid_o = (state_q == ST_REPORT);
  assign busy_o       = (state_q != ST_IDLE);
  assign done_tag_o   = tag_q;
  assign done_err_o   = err_q;
  assign base_addra_o = addra_q;
  assign base_addrb_o = addrb_q;
  assign base_addrp_o = addrp_q;
  assign k_o          = k_q;
  assign m_o          = m_q;
  assign n_o          = n_q;

endmodule

// File: tb/tb_mm_job_scheduler.sv
// Scoreboard bench for mm_job_scheduler: directed jobs push expected {tag,err}; a monitor checks each completion.
module tb_mm_job_scheduler;

  localparam int AW    = 16;
  localparam int DEPTH = 4;
  localparam int TO_W  = 16;
  localparam int PW    = $clog2(DEPTH + 1);

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic            job_valid_i = 1'b0;
  logic            job_ready_o;
  logic [AW-1:0]   job_addra_i = '0, job_addrb_i = '0, job_addrp_i = '0;
  logic [3:0]      job_k_i = '0, job_m_i = '0, job_n_i = '0, job_tag_i = '0;
  logic [TO_W-1:0] timeout_cycles_i = '0;
  logic            start_o;
  logic [AW-1:0]   base_addra_o, base_addrb_o, base_addrp_o;
  logic [3:0]      k_o, m_o, n_o;
  logic            ctrl_valid_i = 1'b0;
  logic            done_valid_o;
  logic            done_ready_i = 1'b1;
  logic [3:0]      done_tag_o;
  logic [1:0]      done_err_o;
  logic            busy_o;
  logic [PW-1:0]   pending_o;

  int n_tests = 0;
  int n_fail  = 0;
  int n_start = 0;
  logic prev_start = 1'b0;
  logic [5:0] exp_q [$];

  always #5 clk_i = ~clk_i;

  mm_job_scheduler #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .TO_W(TO_W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .job_valid_i(job_valid_i), .job_ready_o(job_ready_o),
    .job_addra_i(job_addra_i), .job_addrb_i(job_addrb_i), .job_addrp_i(job_addrp_i),
    .job_k_i(job_k_i), .job_m_i(job_m_i), .job_n_i(job_n_i), .job_tag_i(job_tag_i),
    .timeout_cycles_i(timeout_cycles_i),
    .start_o(start_o),
    .base_addra_o(base_addra_o), .base_addrb_o(base_addrb_o), .base_addrp_o(base_addrp_o),
    .k_o(k_o), .m_o(m_o), .n_o(n_o),
    .ctrl_valid_i(ctrl_valid_i),
    .done_valid_o(done_valid_o), .done_ready_i(done_ready_i),
    .done_tag_o(done_tag_o), .done_err_o(done_err_o),
    .busy_o(busy_o), .pending_o(pending_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic mid();
    @(negedge clk_i);
  endtask

  // Completion monitor: every accepted record must match the oldest expectation.
  always @(negedge clk_i) begin
    if (rst_ni && done_valid_o && done_ready_i) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done actual_tag=%0h actual_err=%0h required=none", done_tag_o, done_err_o);
      end else begin
        logic [5:0] e;
        e = exp_q.pop_front();
        chk("done_tag", done_tag_o, e[5:2]);
        chk("done_err", done_err_o, e[1:0]);
      end
    end
  end

  always @(negedge clk_i) begin
    if (start_o) begin
      n_start++;
      if (prev_start) chk("start_single_cycle", 1, 0);
    end
    prev_start = start_o;
  end

  task automatic push(input logic [AW-1:0] a, input logic [AW-1:0] b, input logic [AW-1:0] p,
                      input logic [3:0] k, input logic [3:0] m, input logic [3:0] n,
                      input logic [3:0] tag, input logic [1:0] err, input bit sb);
    bit ok;
    ok = 0;
    job_addra_i = a; job_addrb_i = b; job_addrp_i = p;
    job_k_i = k; job_m_i = m; job_n_i = n; job_tag_i = tag;
    job_valid_i = 1'b1;
    for (int i = 0; i < 100; i++) begin
      mid();
      if (job_ready_o) begin
        ok = 1;
        break;
      end
      tick(1);
    end
    if (!ok) chk("push_ready_timeout", 0, 1);
    @(posedge clk_i);
    #1;
    job_valid_i = 1'b0;
    if (sb && ok) exp_q.push_back({tag, err});
  endtask

  task automatic run_job();
    bit got;
    got = 0;
    for (int i = 0; i < 50; i++) begin
      mid();
      if (start_o) begin
        got = 1;
        break;
      end
      tick(1);
    end
    chk("start_seen", got, 1);
    tick(3);
    ctrl_valid_i = 1'b1;
    tick(1);
    ctrl_valid_i = 1'b0;
  endtask

  initial begin
    int s0;
    // Reset state
    tick(3);
    mid();
    chk("rst_job_ready", job_ready_o, 1);
    chk("rst_pending", pending_o, 0);
    chk("rst_start", start_o, 0);
    chk("rst_done_valid", done_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_addra", base_addra_o, 0);
    chk("rst_k", k_o, 0);
    chk("rst_tag_err", {done_tag_o, done_err_o}, 0);
    tick(1);
    rst_ni = 1'b1;
    tick(2);

    // Single job with launch and completion latency
    push(16'h1000, 16'h2000, 16'h3000, 4, 2, 3, 5, 2'b00, 1);
    mid();
    chk("t1_pending", pending_o, 1);
    chk("t1_no_start_yet", start_o, 0);
    tick(1);
    mid();
    chk("t1_start", start_o, 1);
    chk("t1_addra", base_addra_o, 16'h1000);
    chk("t1_addrb", base_addrb_o, 16'h2000);
    chk("t1_addrp", base_addrp_o, 16'h3000);
    chk("t1_kmn", {k_o, m_o, n_o}, 12'h423);
    chk("t1_pending_after_pop", pending_o, 0);
    tick(1);
    mid();
    chk("t1_start_dropped", start_o, 0);
    chk("t1_busy", busy_o, 1);
    tick(18);
    ctrl_valid_i = 1'b1;
    mid();
    chk("t1_done_not_early", done_valid_o, 0);
    tick(1);
    ctrl_valid_i = 1'b0;
    mid();
    chk("t1_done_valid", done_valid_o, 1);
    chk("t1_addra_held", base_addra_o, 16'h1000);
    tick(1);
    mid();
    chk("t1_done_cleared", done_valid_o, 0);
    chk("t1_idle", busy_o, 0);
    tick(1);

    // Fill the FIFO with the host holding off completions
    done_ready_i = 1'b0;
    for (int i = 0; i < 5; i++)
      push(16'h0100 + 16'(i), 16'h0200, 16'h0300, 1, 1, 1, 4'(i), 2'b00, 1);
    mid();
    chk("fill_pending", pending_o, 4);
    chk("fill_ready_low", job_ready_o, 0);
    job_valid_i = 1'b1;
    job_tag_i = 4'hf;
    tick(2);
    mid();
    chk("fill_blocked_push", pending_o, 4);
    job_valid_i = 1'b0;
    tick(1);
    ctrl_valid_i = 1'b1;
    tick(1);
    ctrl_valid_i = 1'b0;
    s0 = n_start;
    // Backpressure: record must hold and nothing new may launch
    for (int i = 0; i < 10; i++) begin
      mid();
      chk("bp_valid", done_valid_o, 1);
      chk("bp_tag", done_tag_o, 0);
      chk("bp_err", done_err_o, 0);
      tick(1);
    end
    chk("bp_no_start", n_start, s0);
    chk("bp_pending", pending_o, 4);
    done_ready_i = 1'b1;
    tick(1);
    for (int i = 0; i < 4; i++) run_job();
    tick(2);

    // Zero dimension job, then a normal one
    s0 = n_start;
    push(16'h0aaa, 16'h0bbb, 16'h0ccc, 3, 0, 2, 9, 2'b01, 1);
    mid();
    chk("zd_done_not_yet", done_valid_o, 0);
    tick(1);
    mid();
    chk("zd_done_valid", done_valid_o, 1);
    chk("zd_no_start", n_start, s0);
    tick(1);
    push(16'h0111, 16'h0222, 16'h0333, 2, 2, 2, 10, 2'b00, 1);
    run_job();
    tick(2);
    chk("zd_next_launched", n_start, s0 + 1);

    // Timeout with a late controller pulse
    timeout_cycles_i = 16'd8;
    push(16'h0444, 16'h0555, 16'h0666, 1, 2, 3, 11, 2'b10, 1);
    begin
      bit got;
      got = 0;
      for (int i = 0; i < 20; i++) begin
        mid();
        if (start_o) begin
          got = 1;
          break;
        end
        tick(1);
      end
      chk("to_start_seen", got, 1);
    end
    tick(8);
    mid();
    chk("to_not_early", done_valid_o, 0);
    tick(1);
    mid();
    chk("to_done_valid", done_valid_o, 1);
    chk("to_err_direct", done_err_o, 2);
    tick(1);
    ctrl_valid_i = 1'b1;
    tick(1);
    ctrl_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mid();
      chk("to_no_second_done", done_valid_o, 0);
      tick(1);
    end
    timeout_cycles_i = '0;

    // Reset mid-RUN with two jobs queued
    for (int i = 0; i < 3; i++)
      push(16'h0700, 16'h0800, 16'h0900, 2, 3, 4, 4'(12 + i), 2'b00, 0);
    tick(2);
    mid();
    chk("rr_pending_before", pending_o, 2);
    chk("rr_busy_before", busy_o, 1);
    #1 rst_ni = 1'b0;
    #1;
    chk("rr_start", start_o, 0);
    chk("rr_done_valid", done_valid_o, 0);
    chk("rr_busy", busy_o, 0);
    chk("rr_pending", pending_o, 0);
    chk("rr_ready", job_ready_o, 1);
    chk("rr_addrs", {base_addra_o, base_addrb_o}, 0);
    chk("rr_dims_tag", {k_o, m_o, n_o, done_tag_o, done_err_o}, 0);
    tick(2);
    rst_ni = 1'b1;
    s0 = n_start;
    tick(6);
    mid();
    chk("rr_no_start_after", n_start, s0);
    chk("rr_idle_after", busy_o, 0);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
